// File: rtl/if_stage_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage (master) drives the word address. The memory (slave)
// returns the instruction word combinationally.
interface if_stage_fetch_if #(
  parameter int unsigned IMEM_AW = 8
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the fetched word into the IF/ID pipeline register.
// Redirect priority per edge: EX branch > stall > ID jump > sequential.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt/bubble_cnt performance counters.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  id_jump,
  input  logic [31:0]           id_jump_target,
  input  logic                  ex_branch_taken,
  input  logic [31:0]           ex_branch_target,
  if_stage_fetch_if.master      imem,
  output logic [31:0]           pc_out,
  output logic [31:0]           if_id_inst,
  output logic [31:0]           if_id_pc_plus4,
  output logic                  if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_pc_plus4_nxt;
  logic        w_valid_nxt;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign imem.imem_addr = r_pc[IMEM_AW+1:2];

  assign pc_out         = r_pc;
  assign if_id_inst     = r_inst;
  assign if_id_pc_plus4 = r_pc_plus4;
  assign if_id_valid    = r_valid;

  // Next-state selection in redirect priority order; stall holds everything.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_inst;
    w_pc_plus4_nxt = r_pc_plus4;
    w_valid_nxt    = r_valid;
    if (ex_branch_taken) begin
      w_pc_nxt       = {ex_branch_target[31:2], 2'b00};
      w_inst_nxt     = NOP_INST;
      w_pc_plus4_nxt = '0;
      w_valid_nxt    = 1'b0;
    end else if (stall) begin
      w_pc_nxt       = r_pc;
    end else if (id_jump) begin
      w_pc_nxt       = {id_jump_target[31:2], 2'b00};
      w_inst_nxt     = NOP_INST;
      w_pc_plus4_nxt = '0;
      w_valid_nxt    = 1'b0;
    end else begin
      w_pc_nxt       = w_pc_plus4;
      w_inst_nxt     = imem.imem_rdata;
      w_pc_plus4_nxt = w_pc_plus4;
      w_valid_nxt    = 1'b1;
    end
  end

  // PC and IF/ID register update with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inst     <= NOP_INST;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_pc_plus4 <= w_pc_plus4_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_fetch_evt;
  logic        w_bubble_evt;

  assign w_fetch_evt  = !ex_branch_taken && !stall && !id_jump;
  assign w_bubble_evt = ex_branch_taken || (!stall && id_jump);
  assign fetch_cnt    = r_fetch_cnt;
  assign bubble_cnt   = r_bubble_cnt;

  // Count valid fetches and redirect bubbles; stall edges count neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_fetch_evt)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_bubble_evt) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed self-checking bench for if_stage_fetch. Instruction memory model
// returns 32'h1000_0000 | word_address.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        id_jump = 1'b0;
  logic [31:0] id_jump_target = '0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = '0;
  logic [31:0] pc_out;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int unsigned checks = 0;
  int unsigned passed = 0;

  if_stage_fetch_if #(.IMEM_AW(8)) imem_bus ();
  assign imem_bus.imem_rdata = 32'h1000_0000 | {24'h0, imem_bus.imem_addr};

  if_stage_fetch #(
    .RESET_PC(32'h0000_0000),
    .IMEM_AW(8),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .id_jump(id_jump),
    .id_jump_target(id_jump_target),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .imem(imem_bus),
    .pc_out(pc_out),
    .if_id_inst(if_id_inst),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; id_jump = 1'b0; id_jump_target = '0;
    ex_branch_taken = 1'b0; ex_branch_target = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got=%h exp=%h", pc_out, 32'h0); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", if_id_valid); else passed++;
    checks++; if (if_id_inst !== 32'h0) $display("FAIL rst_inst got=%h exp=%h", if_id_inst, 32'h0); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL rst_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h0); else passed++;
    step();
    rst = 1'b1;
    #1;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL pre_edge_valid got=%b exp=0", if_id_valid); else passed++;
    checks++; if (if_id_inst !== 32'h0) $display("FAIL pre_edge_inst got=%h exp=%h", if_id_inst, 32'h0); else passed++;
    step(); step(); step();
    checks++; if (pc_out !== 32'd12) $display("FAIL seq_pc got=%h exp=%h", pc_out, 32'd12); else passed++;
    checks++; if (if_id_inst !== 32'h1000_0002) $display("FAIL seq_inst got=%h exp=%h", if_id_inst, 32'h1000_0002); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'd12) $display("FAIL seq_pp4 got=%h exp=%h", if_id_pc_plus4, 32'd12); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL seq_valid got=%b exp=1", if_id_valid); else passed++;
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd3) $display("FAIL seq_fetch_cnt got=%0d exp=3", fetch_cnt); else passed++;
    checks++; if (bubble_cnt !== 32'd0) $display("FAIL seq_bubble_cnt got=%0d exp=0", bubble_cnt); else passed++;
`endif
  endtask

  task automatic test_stall();
    apply_reset();
    step(); step();
    stall = 1'b1;
    id_jump = 1'b1; id_jump_target = 32'h0000_0300;
    step(); step();
    checks++; if (pc_out !== 32'd8) $display("FAIL stall_pc got=%h exp=%h", pc_out, 32'd8); else passed++;
    checks++; if (if_id_inst !== 32'h1000_0001) $display("FAIL stall_inst got=%h exp=%h", if_id_inst, 32'h1000_0001); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'd8) $display("FAIL stall_pp4 got=%h exp=%h", if_id_pc_plus4, 32'd8); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL stall_valid got=%b exp=1", if_id_valid); else passed++;
    clear_inputs();
    step();
    checks++; if (if_id_inst !== 32'h1000_0002) $display("FAIL unstall_inst got=%h exp=%h", if_id_inst, 32'h1000_0002); else passed++;
    checks++; if (pc_out !== 32'd12) $display("FAIL unstall_pc got=%h exp=%h", pc_out, 32'd12); else passed++;
  endtask

  task automatic test_jump();
    apply_reset();
    step(); step(); step(); step();
    checks++; if (pc_out !== 32'd16) $display("FAIL jmp_start_pc got=%h exp=%h", pc_out, 32'd16); else passed++;
    id_jump = 1'b1; id_jump_target = 32'h0000_0040;
    step();
    checks++; if (pc_out !== 32'h40) $display("FAIL jmp_pc got=%h exp=%h", pc_out, 32'h40); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL jmp_valid got=%b exp=0", if_id_valid); else passed++;
    checks++; if (if_id_inst !== 32'h0) $display("FAIL jmp_inst got=%h exp=%h", if_id_inst, 32'h0); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL jmp_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h0); else passed++;
    clear_inputs();
    step();
    checks++; if (if_id_inst !== 32'h1000_0010) $display("FAIL jmp_next_inst got=%h exp=%h", if_id_inst, 32'h1000_0010); else passed++;
    checks++; if (pc_out !== 32'h44) $display("FAIL jmp_next_pc got=%h exp=%h", pc_out, 32'h44); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h44) $display("FAIL jmp_next_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h44); else passed++;
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd5) $display("FAIL jmp_fetch_cnt got=%0d exp=5", fetch_cnt); else passed++;
    checks++; if (bubble_cnt !== 32'd1) $display("FAIL jmp_bubble_cnt got=%0d exp=1", bubble_cnt); else passed++;
`endif
  endtask

  task automatic test_branch_priority();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0023;
    stall = 1'b1;
    id_jump = 1'b1; id_jump_target = 32'h0000_0080;
    step();
    checks++; if (pc_out !== 32'h20) $display("FAIL br_pc got=%h exp=%h", pc_out, 32'h20); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL br_valid got=%b exp=0", if_id_valid); else passed++;
    checks++; if (if_id_inst !== 32'h0) $display("FAIL br_inst got=%h exp=%h", if_id_inst, 32'h0); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL br_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h0); else passed++;
    clear_inputs();
    step();
    checks++; if (if_id_inst !== 32'h1000_0008) $display("FAIL br_next_inst got=%h exp=%h", if_id_inst, 32'h1000_0008); else passed++;
    checks++; if (pc_out !== 32'h24) $display("FAIL br_next_pc got=%h exp=%h", pc_out, 32'h24); else passed++;
  endtask

  task automatic test_wrap();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_br_pc got=%h exp=%h", pc_out, 32'hFFFF_FFFC); else passed++;
    clear_inputs();
    step();
    checks++; if (pc_out !== 32'h0) $display("FAIL wrap_pc got=%h exp=%h", pc_out, 32'h0); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL wrap_pp4 got=%h exp=%h", if_id_pc_plus4, 32'h0); else passed++;
    checks++; if (if_id_inst !== 32'h1000_00FF) $display("FAIL wrap_inst got=%h exp=%h", if_id_inst, 32'h1000_00FF); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL wrap_valid got=%b exp=1", if_id_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    id_jump = 1'b1; id_jump_target = 32'h0000_0100;
    step();
    id_jump_target = 32'h0000_0202;
    step();
    checks++; if (pc_out !== 32'h200) $display("FAIL b2b_pc got=%h exp=%h", pc_out, 32'h200); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL b2b_valid got=%b exp=0", if_id_valid); else passed++;
    clear_inputs();
    step();
    checks++; if (if_id_inst !== 32'h1000_0080) $display("FAIL b2b_inst got=%h exp=%h", if_id_inst, 32'h1000_0080); else passed++;
    checks++; if (pc_out !== 32'h204) $display("FAIL b2b_next_pc got=%h exp=%h", pc_out, 32'h204); else passed++;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    #1;
    checks++; if (fetch_cnt !== 32'd0) $display("FAIL perf_rst_fetch got=%0d exp=0", fetch_cnt); else passed++;
    checks++; if (bubble_cnt !== 32'd0) $display("FAIL perf_rst_bubble got=%0d exp=0", bubble_cnt); else passed++;
    step(); step();
    id_jump = 1'b1; id_jump_target = 32'h0000_0040;
    step();
    clear_inputs();
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    checks++; if (fetch_cnt !== 32'd3) $display("FAIL perf_fetch got=%0d exp=3", fetch_cnt); else passed++;
    checks++; if (bubble_cnt !== 32'd1) $display("FAIL perf_bubble got=%0d exp=1", bubble_cnt); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    step(); step(); step();
    stall = 1'b1;
    step();
    #3;
    rst = 1'b0;
    #1;
    checks++; if (pc_out !== 32'h0) $display("FAIL arst_pc got=%h exp=%h", pc_out, 32'h0); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", if_id_valid); else passed++;
    checks++; if (if_id_inst !== 32'h0) $display("FAIL arst_inst got=%h exp=%h", if_id_inst, 32'h0); else passed++;
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd0) $display("FAIL arst_fetch got=%0d exp=0", fetch_cnt); else passed++;
    checks++; if (bubble_cnt !== 32'd0) $display("FAIL arst_bubble got=%0d exp=0", bubble_cnt); else passed++;
`endif
    step();
    rst = 1'b1;
    stall = 1'b0;
    step();
    checks++; if (pc_out !== 32'd4) $display("FAIL arst_rel_pc got=%h exp=%h", pc_out, 32'd4); else passed++;
    checks++; if (if_id_inst !== 32'h1000_0000) $display("FAIL arst_rel_inst got=%h exp=%h", if_id_inst, 32'h1000_0000); else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_back_to_back();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
